ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the sending side of the PS/2 port whose receiver decodes keyboard and mouse scancodes. It runs the request-to-send sequence and shifts one command byte out to the device, for example 0xED (set LEDs) or 0xF4 (enable mouse reporting). It then checks the device's acknowledge bit. It drives the open-collector PS/2 lines through active-high pull-low enables and shares the external ps2clk/ps2data pins with the receiver.

---
 rtl/ps2_host_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame shift and ack check.
// Optional `PS2TX_CLK_FILTER_EN adds an 8-sample glitch filter on the synchronized device clock.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAITIDLE
  } state_t;

  // Two-flop synchronizers; idle bus level is high, so reset to 1.
  logic [1:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic       clk_s;
  logic       data_s;
  logic       clk_level;
  logic       clk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2clk_ext};
      data_sync_reg <= {data_sync_reg[0], ps2data_ext};
    end
  end

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

`ifdef PS2TX_CLK_FILTER_EN
  logic [7:0] filt_sr_reg;
  logic       filt_reg;

  // Level only flips after eight identical stored samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_sr_reg <= 8'hff;
      filt_reg    <= 1'b1;
    end else begin
      filt_sr_reg <= {filt_sr_reg[6:0], clk_s};
      if (filt_sr_reg == 8'hff) begin
        filt_reg <= 1'b1;
      end else if (filt_sr_reg == 8'h00) begin
        filt_reg <= 1'b0;
      end
    end
  end

  assign clk_level = filt_reg;
  assign clk_fall  = filt_reg & (filt_sr_reg == 8'h00);
`else
  logic clk_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= clk_s;
    end
  end

  assign clk_level = clk_s;
  assign clk_fall  = clk_prev_reg & ~clk_s;
`endif

  state_t        state_reg, state_next;
  logic [IW-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    edge_cnt_reg, edge_cnt_next;
  logic [9:0]    frame_reg, frame_next;
  logic          drive_reg, drive_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          ack_err_reg, ack_err_next;
  logic          timeout_reg, timeout_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      inh_cnt_reg  <= '0;
      timer_reg    <= '0;
      edge_cnt_reg <= '0;
      frame_reg    <= '0;
      drive_reg    <= 1'b0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inh_cnt_reg  <= inh_cnt_next;
      timer_reg    <= timer_next;
      edge_cnt_reg <= edge_cnt_next;
      frame_reg    <= frame_next;
      drive_reg    <= drive_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ack_err_reg  <= ack_err_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    inh_cnt_next  = inh_cnt_reg;
    timer_next    = timer_reg;
    edge_cnt_next = edge_cnt_reg;
    frame_next    = frame_reg;
    drive_next    = drive_reg;
    done_next     = 1'b0;
    ack_err_next  = 1'b0;
    timeout_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          // Frame shifts out LSB first: data[7:0], odd parity, stop.
          frame_next    = {1'b1, ~^data_in, data_in};
          inh_cnt_next  = IW'(INHIBIT_CYCLES - 1);
          edge_cnt_next = 4'd0;
          state_next    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_reg == '0) begin
          state_next = S_REQ;
        end else begin
          inh_cnt_next = inh_cnt_reg - IW'(1);
        end
      end

      S_REQ: begin
        drive_next = 1'b1;
        timer_next = TW'(TIMEOUT_CYCLES - 1);
        state_next = S_SHIFT;
      end

      S_SHIFT, S_ACK, S_WAITIDLE: begin
        if (clk_fall) begin
          timer_next = TW'(TIMEOUT_CYCLES - 1);
          if (edge_cnt_reg != 4'd11) begin
            edge_cnt_next = edge_cnt_reg + 4'd1;
          end
        end

        if (!clk_fall && timer_reg == '0) begin
          timeout_next = 1'b1;
          drive_next   = 1'b0;
          state_next   = S_IDLE;
        end else begin
          if (!clk_fall) begin
            timer_next = timer_reg - TW'(1);
          end
          if (state_reg == S_SHIFT) begin
            if (clk_fall) begin
              drive_next = ~frame_reg[0];
              frame_next = {1'b1, frame_reg[9:1]};
              // Tenth edge has just put the stop bit out; next edge is the ack.
              if (edge_cnt_reg == 4'd9) begin
                state_next = S_ACK;
              end
            end
          end else if (state_reg == S_ACK) begin
            if (clk_fall) begin
              if (data_s) begin
                ack_err_next = 1'b1;
                state_next   = S_IDLE;
              end else begin
                state_next = S_WAITIDLE;
              end
            end
          end else begin
            if (clk_level && data_s) begin
              done_next  = 1'b1;
              state_next = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Pin enables are registered so the open-collector drivers never glitch.
    clk_oe_next  = (state_next == S_INHIBIT);
    data_oe_next = (state_next == S_REQ) | ((state_next == S_SHIFT) & drive_next);
    busy_next    = (state_next != S_IDLE);
  end

  assign ps2clk_oe  = clk_oe_reg;
  assign ps2data_oe = data_oe_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ack_err    = ack_err_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: random bytes against a PS/2 device model, checked through a status scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 300;
  localparam int H   = 20;
`ifdef PS2TX_CLK_FILTER_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk_ext, ps2data_ext;
  logic       ps2clk_oe, ps2data_oe;
  logic       busy, done, ack_err, timeout;

  // Wired-AND open-collector bus.
  assign ps2clk_ext  = dev_clk & ~ps2clk_oe;
  assign ps2data_ext = dev_data & ~ps2data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe), .data_in(data_in), .start(start),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int kind; int nbits; logic [10:0] frame; int at_cyc; } exp_t;
  typedef struct { int nbits; logic [10:0] bits; } cap_t;
  exp_t exp_q[$];
  cap_t cap_q[$];

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Line-order frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // mode 0 normal, 1 stall after edge 4, 2 reset during shift, 3 clock glitch before edge 4
  task automatic device(input int mode, input logic ack, output int f4_cyc);
    cap_t c;
    c.bits  = '0;
    c.nbits = 0;
    f4_cyc  = 0;
    for (int k = 1; k <= 11; k++) begin
      repeat (H) @(negedge clk);
      if (mode == 3 && k == 4) begin
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
      end
      c.bits[k-1] = ps2data_ext;
      c.nbits     = k;
      if (k == 11) begin
        cap_q.push_back(c);
        dev_data = ack;
      end
      repeat (2) @(negedge clk);
      dev_clk = 1'b0;
      if (k == 4) f4_cyc = cyc;
      if (k == 6) begin
        start   = 1'b1;
        data_in = ~data_in;
        @(negedge clk);
        start = 1'b0;
      end
      repeat (H) @(negedge clk);
      if (mode == 2 && k == 5) begin
        check("pre_reset_data_oe", ps2data_oe, 1);
        rst_n = 1'b0;
        #1;
        check("reset_clk_oe", ps2clk_oe, 0);
        check("reset_data_oe", ps2data_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_pulses", {done, ack_err, timeout}, 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      if (mode == 1 && k == 4) begin
        cap_q.push_back(c);
        break;
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int mode, input logic ack);
    exp_t e;
    int   n;
    int   f4;
    @(negedge clk);
    data_in = b;
    start   = 1'b1;
    e.frame  = model_frame(b);
    e.kind   = ack ? 1 : 0;
    e.nbits  = 11;
    e.at_cyc = -1;
    if (mode == 1) begin
      e.kind  = 2;
      e.nbits = 4;
    end
    if (mode == 0 || mode == 3) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("inhibit_clk_oe", ps2clk_oe, 1);
    check("inhibit_data_oe", ps2data_oe, 0);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("req_data_oe", ps2data_oe, 1);
    check("req_clk_oe", ps2clk_oe, 0);
    device(mode, ack, f4);
    if (mode == 1) begin
      e.at_cyc = f4 + LAT + TO;
      exp_q.push_back(e);
      while (cyc < e.at_cyc - 1) @(negedge clk);
      start   = 1'b1;
      data_in = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("start_ignored_busy", busy, 0);
      check("start_ignored_clk_oe", ps2clk_oe, 0);
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      check("in_reset_outputs", {ps2clk_oe, ps2data_oe, busy, done, ack_err, timeout}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 2 * TO) begin
        n++;
        @(negedge clk);
      end
      check("transfer_ends", busy, 0);
      repeat (2) @(negedge clk);
    end
  endtask

  // Monitor: pops the scoreboard whenever a status pulse appears.
  initial begin
    logic pb;
    int   n, kind, mask;
    exp_t e;
    cap_t c;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      n = int'(done) + int'(ack_err) + int'(timeout);
      if (rst_n) begin
        if (pb && !busy) check("status_at_busy_fall", int'(n != 0), 1);
        if (n != 0) begin
          check("one_status_pulse", n, 1);
          check("busy_low_at_pulse", busy, 0);
          check("busy_before_pulse", pb, 1);
          check("oe_released", {ps2clk_oe, ps2data_oe}, 0);
          kind = done ? 0 : (ack_err ? 1 : 2);
          check("sb_expect_present", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("status_kind", kind, e.kind);
            if (e.at_cyc >= 0) check("timeout_cycle", cyc, e.at_cyc);
            check("frame_present", int'(cap_q.size() > 0), 1);
            if (cap_q.size() > 0) begin
              c    = cap_q.pop_front();
              mask = (1 << e.nbits) - 1;
              check("frame_len", c.nbits, e.nbits);
              check("frame_bits", int'(c.bits) & mask, int'(e.frame) & mask);
            end
          end
        end
      end
      pb = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic       a;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2clk_oe, 0);
    check("rst_data_oe", ps2data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hF4, 0, 1'b0);
    send(8'hED, 0, 1'b0);
    send(8'($urandom_range(0, 255)), 0, 1'b1);
    send(8'($urandom_range(0, 255)), 1, 1'b0);
    send(8'h00, 2, 1'b0);
    send(8'h55, 0, 1'b0);
`ifdef PS2TX_CLK_FILTER_EN
    send(8'($urandom_range(0, 255)), 3, 1'b0);
`endif
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 3) == 0);
      send(b, 0, a);
    end

    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("cap_drained", cap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
